tb_csr_initiator: RTL and testbench

// Bench-side CSR initiator: drives the Hypercorex CSR request/response port from a preloaded command list.
// Per command: one CSR write, read or poll, with at most one request outstanding.

---
 rtl/tb_csr_initiator.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tb_csr_initiator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_csr_initiator.sv
// tb_csr_initiator: bench-side CSR initiator.
// Executes a preloaded command list (WRITE / READ / POLL / END) against a
// CSR valid/ready request/response port, one request outstanding at a time.
// READ data is captured into a result memory that the bench reads back.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cmd_wr_addr_i/_data_i/_en_i  command memory write port (ignored while busy)
//   start_i                 start executing from entry 0 (ignored while busy)
//   busy_o                  sequence running (FETCH/REQ/RSP)
//   done_o                  sequence finished, sticky until next start
//   timeout_o               poll exhausted PollMax attempts, sticky until next start
//   overflow_o              READ with result memory full, sticky until next start
//   num_reads_o             number of results stored
//   csr_req_*               CSR request channel (initiator side)
//   csr_rsp_*               CSR response channel (initiator side)
//   res_rd_addr_i/_data_o   combinational result memory read port
module tb_csr_initiator #(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned CsrAddrWidth = 32,
  parameter int unsigned CmdDepth     = 64,
  parameter int unsigned ResDepth     = 64,
  parameter int unsigned PollMax      = 1024,
  parameter int unsigned CmdWidth     = 2 + CsrAddrWidth + CsrDataWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [$clog2(CmdDepth)-1:0]   cmd_wr_addr_i,
  input  logic [CmdWidth-1:0]           cmd_wr_data_i,
  input  logic                          cmd_wr_en_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic                          overflow_o,
  output logic [$clog2(ResDepth):0]     num_reads_o,
  output logic [CsrDataWidth-1:0]       csr_req_data_o,
  output logic [CsrAddrWidth-1:0]       csr_req_addr_o,
  output logic                          csr_req_write_o,
  output logic                          csr_req_valid_o,
  input  logic                          csr_req_ready_i,
  input  logic [CsrDataWidth-1:0]       csr_rsp_data_i,
  input  logic                          csr_rsp_valid_i,
  output logic                          csr_rsp_ready_o,
  input  logic [$clog2(ResDepth)-1:0]   res_rd_addr_i,
  output logic [CsrDataWidth-1:0]       res_rd_data_o
);

  localparam int unsigned CmdAw = $clog2(CmdDepth);
  localparam int unsigned ResAw = $clog2(ResDepth);
  localparam int unsigned CntW  = $clog2(ResDepth) + 1;
  localparam int unsigned PollW = $clog2(PollMax) + 1;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;
  localparam logic [1:0] OpEnd   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [CmdWidth-1:0]     r_cmd_mem [CmdDepth];
  logic [CsrDataWidth-1:0] r_res_mem [ResDepth];

  logic [CmdAw-1:0]        r_pc, w_pc_next;
  logic [CntW-1:0]         r_res_ptr, w_res_ptr_next;
  logic [PollW-1:0]        r_poll_cnt, w_poll_cnt_next;
  logic [1:0]              r_op;
  logic [CsrAddrWidth-1:0] r_addr;
  logic [CsrDataWidth-1:0] r_data;
  logic                    r_done, w_done_next;
  logic                    r_timeout, w_timeout_next;
  logic                    r_overflow, w_overflow_next;
  logic                    r_busy;
  logic                    r_req_valid;
  logic                    r_rsp_ready;

  logic                    w_latch;
  logic                    w_res_we;
  logic                    w_advance;
  logic                    w_poll_met;

  logic [CmdWidth-1:0]     w_cmd_word;
  logic [1:0]              w_cmd_op;
  logic [CsrAddrWidth-1:0] w_cmd_addr;
  logic [CsrDataWidth-1:0] w_cmd_data;

  // Decode the command at the current program counter
  assign w_cmd_word = r_cmd_mem[r_pc];
  assign w_cmd_op   = w_cmd_word[CmdWidth-1 -: 2];
  assign w_cmd_addr = w_cmd_word[CsrAddrWidth+CsrDataWidth-1 -: CsrAddrWidth];
  assign w_cmd_data = w_cmd_word[CsrDataWidth-1:0];

  assign w_poll_met = ((csr_rsp_data_i & r_data) == r_data);

  // Command memory: writable only while the sequencer is not running
  always_ff @(posedge clk_i) begin
    if (cmd_wr_en_i && !r_busy) begin
      r_cmd_mem[cmd_wr_addr_i] <= cmd_wr_data_i;
    end
  end

  // Result memory: one entry per accepted READ response
  always_ff @(posedge clk_i) begin
    if (w_res_we) begin
      r_res_mem[r_res_ptr[ResAw-1:0]] <= csr_rsp_data_i;
    end
  end

  assign res_rd_data_o = r_res_mem[res_rd_addr_i];

  // State, counters, request registers and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_res_ptr   <= '0;
      r_poll_cnt  <= '0;
      r_op        <= OpWrite;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_req_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_res_ptr   <= w_res_ptr_next;
      r_poll_cnt  <= w_poll_cnt_next;
      r_done      <= w_done_next;
      r_timeout   <= w_timeout_next;
      r_overflow  <= w_overflow_next;
      r_busy      <= (w_state_next == S_FETCH) || (w_state_next == S_REQ) ||
                     (w_state_next == S_RSP);
      r_req_valid <= (w_state_next == S_REQ);
      r_rsp_ready <= (w_state_next == S_RSP);
      if (w_latch) begin
        r_op   <= w_cmd_op;
        r_addr <= w_cmd_addr;
        r_data <= w_cmd_data;
      end
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_res_ptr_next  = r_res_ptr;
    w_poll_cnt_next = r_poll_cnt;
    w_done_next     = r_done;
    w_timeout_next  = r_timeout;
    w_overflow_next = r_overflow;
    w_latch         = 1'b0;
    w_res_we        = 1'b0;
    w_advance       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_next    = S_FETCH;
          w_pc_next       = '0;
          w_res_ptr_next  = '0;
          w_poll_cnt_next = '0;
          w_done_next     = 1'b0;
          w_timeout_next  = 1'b0;
          w_overflow_next = 1'b0;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_FETCH: begin
        w_latch         = 1'b1;
        w_poll_cnt_next = '0;
        if (w_cmd_op == OpEnd) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = S_REQ;
        end
      end

      S_REQ: begin
        if (csr_req_ready_i) begin
          w_state_next = S_RSP;
        end
      end

      S_RSP: begin
        if (csr_rsp_valid_i) begin
          case (r_op)
            OpWrite: w_advance = 1'b1;
            OpRead: begin
              if (r_res_ptr < CntW'(ResDepth)) begin
                w_res_we       = 1'b1;
                w_res_ptr_next = r_res_ptr + CntW'(1);
              end else begin
                w_overflow_next = 1'b1;
              end
              w_advance = 1'b1;
            end
            OpPoll: begin
              if (w_poll_met) begin
                w_poll_cnt_next = '0;
                w_advance       = 1'b1;
              end else if (r_poll_cnt < PollW'(PollMax - 1)) begin
                w_poll_cnt_next = r_poll_cnt + PollW'(1);
                w_state_next    = S_REQ;
              end else begin
                w_timeout_next = 1'b1;
                w_done_next    = 1'b1;
                w_state_next   = S_DONE;
              end
            end
            default: begin
              w_done_next  = 1'b1;
              w_state_next = S_DONE;
            end
          endcase
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    // Completing the last entry ends the list as an implicit END
    if (w_advance) begin
      if (r_pc == CmdAw'(CmdDepth - 1)) begin
        w_done_next  = 1'b1;
        w_state_next = S_DONE;
      end else begin
        w_pc_next    = r_pc + CmdAw'(1);
        w_state_next = S_FETCH;
      end
    end
  end

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign timeout_o       = r_timeout;
  assign overflow_o      = r_overflow;
  assign num_reads_o     = r_res_ptr;
  assign csr_req_data_o  = r_data;
  assign csr_req_addr_o  = r_addr;
  assign csr_req_write_o = (r_op == OpWrite);
  assign csr_req_valid_o = r_req_valid;
  assign csr_rsp_ready_o = r_rsp_ready;

endmodule

// File: tb/tb_tb_csr_initiator.sv
// Testbench for tb_csr_initiator: directed command lists, a responder that
// models the CSR target, and a scoreboard of expected requests/responses.
module tb_tb_csr_initiator;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned CD   = 8;
  localparam int unsigned RD   = 2;
  localparam int unsigned PM   = 4;
  localparam int unsigned CW   = 2 + AW + DW;

  localparam logic [1:0] OpW = 2'b00;
  localparam logic [1:0] OpR = 2'b01;
  localparam logic [1:0] OpP = 2'b10;
  localparam logic [1:0] OpE = 2'b11;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic [$clog2(CD)-1:0]   cmd_wr_addr_i = '0;
  logic [CW-1:0]           cmd_wr_data_i = '0;
  logic                    cmd_wr_en_i = 1'b0;
  logic                    start_i = 1'b0;
  logic                    busy_o, done_o, timeout_o, overflow_o;
  logic [$clog2(RD):0]     num_reads_o;
  logic [DW-1:0]           csr_req_data_o;
  logic [AW-1:0]           csr_req_addr_o;
  logic                    csr_req_write_o, csr_req_valid_o;
  logic                    csr_req_ready_i = 1'b1;
  logic [DW-1:0]           csr_rsp_data_i = '0;
  logic                    csr_rsp_valid_i = 1'b0;
  logic                    csr_rsp_ready_o;
  logic [$clog2(RD)-1:0]   res_rd_addr_i = '0;
  logic [DW-1:0]           res_rd_data_o;

  tb_csr_initiator #(
    .CsrDataWidth(DW), .CsrAddrWidth(AW), .CmdDepth(CD), .ResDepth(RD), .PollMax(PM)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_wr_addr_i(cmd_wr_addr_i), .cmd_wr_data_i(cmd_wr_data_i), .cmd_wr_en_i(cmd_wr_en_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .overflow_o(overflow_o), .num_reads_o(num_reads_o),
    .csr_req_data_o(csr_req_data_o), .csr_req_addr_o(csr_req_addr_o),
    .csr_req_write_o(csr_req_write_o), .csr_req_valid_o(csr_req_valid_o),
    .csr_req_ready_i(csr_req_ready_i), .csr_rsp_data_i(csr_rsp_data_i),
    .csr_rsp_valid_i(csr_rsp_valid_i), .csr_rsp_ready_o(csr_rsp_ready_o),
    .res_rd_addr_i(res_rd_addr_i), .res_rd_data_o(res_rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  int rsp_pend = 0;
  int stall_left = 0;
  exp_t        exp_q[$];
  logic [DW-1:0] rsp_q[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // CSR target model: optional request backpressure, one-cycle response pulse
  always @(negedge clk_i) begin
    if (rst_i) begin
      csr_rsp_valid_i = 1'b0;
    end else begin
      if (csr_rsp_valid_i) begin
        csr_rsp_valid_i = 1'b0;
      end else if (csr_rsp_ready_o && rsp_pend > 0) begin
        chk("rsp_queue_nonempty", 96'(rsp_q.size() > 0), 96'(1));
        csr_rsp_data_i  = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
        csr_rsp_valid_i = 1'b1;
        rsp_pend--;
      end
      csr_req_ready_i = (stall_left == 0);
      if (csr_req_valid_o) begin
        if (csr_req_ready_i) begin
          exp_t e;
          n_hs++;
          chk("req_expected", 96'(exp_q.size() > 0), 96'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_fields", {31'd0, csr_req_write_o, csr_req_addr_o, csr_req_data_o},
                {31'd0, e.write, e.addr, e.data});
          end
          rsp_pend++;
        end else begin
          stall_left--;
          if (exp_q.size() > 0)
            chk("req_stable", {31'd0, csr_req_write_o, csr_req_addr_o, csr_req_data_o},
                {31'd0, exp_q[0].write, exp_q[0].addr, exp_q[0].data});
        end
      end
    end
  end

  task automatic load(input int idx, input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    @(negedge clk_i);
    cmd_wr_addr_i = ($clog2(CD))'(idx);
    cmd_wr_data_i = {op, a, d};
    cmd_wr_en_i   = 1'b1;
    @(negedge clk_i);
    cmd_wr_en_i   = 1'b0;
  endtask

  task automatic expect_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] rsp);
    exp_t e;
    e.write = w; e.addr = a; e.data = d;
    exp_q.push_back(e);
    rsp_q.push_back(rsp);
  endtask

  task automatic start_seq();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("busy_after_start", 96'(busy_o), 96'(1));
    chk("done_cleared", 96'(done_o), 96'(0));
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 1;
    while (done_o !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("seq_done", 96'(done_o), 96'(1));
    chk("not_busy", 96'(busy_o), 96'(0));
  endtask

  task automatic check_res(input int idx, input logic [DW-1:0] v);
    res_rd_addr_i = ($clog2(RD))'(idx);
    #1;
    chk("result_mem", 96'(res_rd_data_o), 96'(v));
  endtask

  int cyc;

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_outputs", 96'({busy_o, done_o, timeout_o, overflow_o, csr_req_valid_o, csr_rsp_ready_o}),
        96'(0));
    chk("rst_num_reads", 96'(num_reads_o), 96'(0));
    rst_i = 1'b0;

    // Three writes then END
    load(0, OpW, 32'h100, 32'h1111_1111);
    load(1, OpW, 32'h104, 32'h2222_2222);
    load(2, OpW, 32'h108, 32'h3333_3333);
    load(3, OpE, 32'h0, 32'h0);
    expect_req(1'b1, 32'h100, 32'h1111_1111, 32'h0);
    expect_req(1'b1, 32'h104, 32'h2222_2222, 32'h0);
    expect_req(1'b1, 32'h108, 32'h3333_3333, 32'h0);
    n_hs = 0;
    start_seq();
    wait_done(100, cyc);
    chk("t1_handshakes", 96'(n_hs), 96'(3));
    chk("t1_min_cycles", 96'(cyc + 1 >= 9), 96'(1));
    chk("t1_num_reads", 96'(num_reads_o), 96'(0));
    chk("t1_queue_empty", 96'(exp_q.size()), 96'(0));

    // Two reads captured into the result memory
    load(0, OpR, 32'h10, 32'h0);
    load(1, OpR, 32'h14, 32'h0);
    load(2, OpE, 32'h0, 32'h0);
    expect_req(1'b0, 32'h10, 32'h0, 32'hCAFE_0001);
    expect_req(1'b0, 32'h14, 32'h0, 32'hCAFE_0002);
    n_hs = 0;
    start_seq();
    wait_done(100, cyc);
    chk("t2_handshakes", 96'(n_hs), 96'(2));
    chk("t2_num_reads", 96'(num_reads_o), 96'(2));
    chk("t2_overflow", 96'(overflow_o), 96'(0));
    check_res(0, 32'hCAFE_0001);
    check_res(1, 32'hCAFE_0002);

    // Backpressure; a command write while busy must be ignored
    load(0, OpW, 32'h30, 32'hA5A5_A5A5);
    load(1, OpE, 32'h0, 32'h0);
    expect_req(1'b1, 32'h30, 32'hA5A5_A5A5, 32'h0);
    n_hs = 0;
    stall_left = 5;
    start_seq();
    cmd_wr_addr_i = 3'd1;
    cmd_wr_data_i = {OpW, 32'h34, 32'h5A5A_5A5A};
    cmd_wr_en_i   = 1'b1;
    @(negedge clk_i);
    cmd_wr_en_i   = 1'b0;
    wait_done(100, cyc);
    chk("t3_handshakes", 96'(n_hs), 96'(1));
    chk("t3_stall_consumed", 96'(stall_left), 96'(0));

    // Poll met on the third response, then advance to the next write
    load(0, OpP, 32'h20, 32'h1);
    load(1, OpW, 32'h24, 32'hBEEF);
    load(2, OpE, 32'h0, 32'h0);
    expect_req(1'b0, 32'h20, 32'h1, 32'h2);
    expect_req(1'b0, 32'h20, 32'h1, 32'h0);
    expect_req(1'b0, 32'h20, 32'h1, 32'h3);
    expect_req(1'b1, 32'h24, 32'hBEEF, 32'h0);
    n_hs = 0;
    start_seq();
    wait_done(100, cyc);
    chk("t4_handshakes", 96'(n_hs), 96'(4));
    chk("t4_timeout", 96'(timeout_o), 96'(0));
    chk("t4_num_reads", 96'(num_reads_o), 96'(0));

    // Poll never met: PollMax requests then timeout, following write skipped
    load(0, OpP, 32'h28, 32'h80);
    load(1, OpW, 32'h2C, 32'h1);
    load(2, OpE, 32'h0, 32'h0);
    for (int i = 0; i < int'(PM); i++) expect_req(1'b0, 32'h28, 32'h80, 32'h7F);
    n_hs = 0;
    start_seq();
    wait_done(100, cyc);
    repeat (3) @(negedge clk_i);
    chk("t5_handshakes", 96'(n_hs), 96'(PM));
    chk("t5_timeout", 96'(timeout_o), 96'(1));
    chk("t5_done_sticky", 96'(done_o), 96'(1));

    // Result memory overflow on the third read
    load(0, OpR, 32'h40, 32'h0);
    load(1, OpR, 32'h44, 32'h0);
    load(2, OpR, 32'h48, 32'h0);
    load(3, OpE, 32'h0, 32'h0);
    expect_req(1'b0, 32'h40, 32'h0, 32'hD0);
    expect_req(1'b0, 32'h44, 32'h0, 32'hD1);
    expect_req(1'b0, 32'h48, 32'h0, 32'hD2);
    n_hs = 0;
    chk("t6_timeout_before", 96'(timeout_o), 96'(1));
    start_seq();
    chk("t6_timeout_cleared", 96'(timeout_o), 96'(0));
    wait_done(100, cyc);
    chk("t6_handshakes", 96'(n_hs), 96'(3));
    chk("t6_num_reads", 96'(num_reads_o), 96'(2));
    chk("t6_overflow", 96'(overflow_o), 96'(1));
    check_res(0, 32'hD0);
    check_res(1, 32'hD1);

    // Reset while stalled in REQ, then rerun from entry 0
    load(0, OpW, 32'h50, 32'h77);
    load(1, OpE, 32'h0, 32'h0);
    expect_req(1'b1, 32'h50, 32'h77, 32'h0);
    stall_left = 1000;
    start_seq();
    repeat (2) @(negedge clk_i);
    chk("t7_in_req", 96'(csr_req_valid_o), 96'(1));
    rst_i = 1'b1;
    #1;
    chk("t7_valid_dropped", 96'(csr_req_valid_o), 96'(0));
    chk("t7_busy_dropped", 96'(busy_o), 96'(0));
    chk("t7_overflow_reset", 96'(overflow_o), 96'(0));
    exp_q.delete();
    rsp_q.delete();
    rsp_pend = 0;
    stall_left = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    expect_req(1'b1, 32'h50, 32'h77, 32'h0);
    n_hs = 0;
    start_seq();
    wait_done(100, cyc);
    chk("t7_rerun_handshakes", 96'(n_hs), 96'(1));

    // Full list without END: implicit end after the last entry
    for (int i = 0; i < int'(CD); i++) begin
      load(i, OpW, 32'h200 + 32'(4 * i), 32'(i + 1));
      expect_req(1'b1, 32'h200 + 32'(4 * i), 32'(i + 1), 32'h0);
    end
    n_hs = 0;
    start_seq();
    wait_done(200, cyc);
    repeat (4) @(negedge clk_i);
    chk("t8_handshakes", 96'(n_hs), 96'(CD));
    chk("t8_queue_empty", 96'(exp_q.size()), 96'(0));
    chk("t8_idle_valid", 96'(csr_req_valid_o), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
